// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus shared by the ALU/LSU sources, the register-file write port and the issue-stage hazard queries.
// The arbiter takes the slave modport; the driving side (execute, LSU, issue, bench) takes the master modport.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // valid/ready: a source raises valid and holds addr/data stable until it samples ready high
  // at a rising edge. The transfer happens on that edge. ready never depends on valid.
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic              issue_valid_i;
  logic [ADDR_W-1:0] issue_addr_i;
  logic              issue_busy_o;
  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic              rs1_busy_o;
  logic              rs2_busy_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  issue_valid_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
    output alu_ready_o, lsu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o,
    output issue_busy_o, rs1_busy_o, rs2_busy_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    output issue_valid_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
    input  alu_ready_o, lsu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o,
    input  issue_busy_o, rs1_busy_o, rs2_busy_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU writeback, each with a one-entry
// holding buffer, and keeps the per-register pending-write scoreboard used for RAW/WAW detection.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rf_wb_arbiter_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic              alu_full_q;
  logic [ADDR_W-1:0] alu_addr_q;
  logic [DATA_W-1:0] alu_data_q;
  logic              lsu_full_q;
  logic [ADDR_W-1:0] lsu_addr_q;
  logic [DATA_W-1:0] lsu_data_q;
  logic              prio_q;
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;

  logic alu_acc;
  logic lsu_acc;
  logic alu_win;
  logic lsu_win;

  // ready comes from buffer state only, so a drain is seen one cycle later
  assign bus.alu_ready_o = rst_ni & ~alu_full_q;
  assign bus.lsu_ready_o = rst_ni & ~lsu_full_q;

  assign alu_acc = bus.alu_valid_i & bus.alu_ready_o;
  assign lsu_acc = bus.lsu_valid_i & bus.lsu_ready_o;

  // prio_q only matters when both buffers are full (0 = ALU preferred)
  assign alu_win = alu_full_q & (~lsu_full_q | ~prio_q);
  assign lsu_win = lsu_full_q & ~alu_win;

  assign bus.rf_we_o = rst_ni & (alu_win | lsu_win);

  always_comb begin
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;
    if (rst_ni && alu_win) begin
      bus.rf_waddr_o = alu_addr_q;
      bus.rf_wdata_o = alu_data_q;
    end else if (rst_ni && lsu_win) begin
      bus.rf_waddr_o = lsu_addr_q;
      bus.rf_wdata_o = lsu_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_full_q <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      lsu_full_q <= 1'b0;
      lsu_addr_q <= '0;
      lsu_data_q <= '0;
      prio_q     <= 1'b0;
    end else begin
      // accept and drain never coincide on one buffer: accept needs it empty, drain needs it full
      if (alu_win) alu_full_q <= 1'b0;
      if (lsu_win) lsu_full_q <= 1'b0;
      if (alu_acc && (bus.alu_addr_i != '0)) begin
        alu_full_q <= 1'b1;
        alu_addr_q <= bus.alu_addr_i;
        alu_data_q <= bus.alu_data_i;
      end
      if (lsu_acc && (bus.lsu_addr_i != '0)) begin
        lsu_full_q <= 1'b1;
        lsu_addr_q <= bus.lsu_addr_i;
        lsu_data_q <= bus.lsu_data_i;
      end
      if (alu_full_q && lsu_full_q) prio_q <= ~prio_q;
    end
  end

  // an issue to the register being committed in the same cycle keeps it pending
  always_comb begin
    pending_d = pending_q;
    if (bus.rf_we_o) pending_d[bus.rf_waddr_o] = 1'b0;
    if (bus.issue_valid_i && (bus.issue_addr_i != '0)) pending_d[bus.issue_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign bus.issue_busy_o = rst_ni & pending_q[bus.issue_addr_i];
  assign bus.rs1_busy_o   = rst_ni & pending_q[bus.rs1_addr_i];
  assign bus.rs2_busy_o   = rst_ni & pending_q[bus.rs2_addr_i];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: drivers push expected RF writes into exp_q, a monitor pops on every rf_we.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int W      = ADDR_W + DATA_W;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every RF write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && bus.rf_we_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected actual=%0h_%0h required=none", bus.rf_waddr_o, bus.rf_wdata_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.rf_waddr_o, bus.rf_wdata_o} !== e) begin
          errors++;
          $display("FAIL rf_write actual=%0h_%0h required=%0h_%0h",
                   bus.rf_waddr_o, bus.rf_wdata_o, e[W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic alu_send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit wr);
    bit ok;
    ok = 0;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = a; bus.alu_data_i = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.alu_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("alu_ready_timeout", 0, 1);
    if (wr) exp_q.push_back({a, d});
    @(posedge clk); #1;
    bus.alu_valid_i = 1'b0;
  endtask

  task automatic lsu_send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit wr);
    bit ok;
    ok = 0;
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = a; bus.lsu_data_i = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.lsu_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("lsu_ready_timeout", 0, 1);
    if (wr) exp_q.push_back({a, d});
    @(posedge clk); #1;
    bus.lsu_valid_i = 1'b0;
  endtask

  task automatic both_send(input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                           input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                           input bit alu_first);
    bit ok;
    ok = 0;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = aa; bus.alu_data_i = ad;
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = la; bus.lsu_data_i = ld;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.alu_ready_o && bus.lsu_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("both_ready_timeout", 0, 1);
    if (alu_first) begin exp_q.push_back({aa, ad}); exp_q.push_back({la, ld}); end
    else           begin exp_q.push_back({la, ld}); exp_q.push_back({aa, ad}); end
    @(posedge clk); #1;
    bus.alu_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    bit a_acc, l_acc;
    int na, nl;
    rst_n = 1'b0;
    bus.alu_valid_i = 0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
    bus.lsu_valid_i = 0; bus.lsu_addr_i = '0; bus.lsu_data_i = '0;
    bus.issue_valid_i = 0; bus.issue_addr_i = '0;
    bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;

    // reset values
    #12;
    check("rst_alu_ready", bus.alu_ready_o, 0);
    check("rst_lsu_ready", bus.lsu_ready_o, 0);
    check("rst_rf_we", bus.rf_we_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_alu_ready", bus.alu_ready_o, 1);
    check("post_rst_lsu_ready", bus.lsu_ready_o, 1);

    // reset mid-transfer with ALU buffer full and x9 pending: stale entry must never be written
    bus.issue_valid_i = 1; bus.issue_addr_i = 9;
    bus.alu_valid_i = 1; bus.alu_addr_i = 9; bus.alu_data_i = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus.alu_valid_i = 0; bus.issue_valid_i = 0;
    check("full_before_rst_we", bus.rf_we_o, 1);
    rst_n = 1'b0; #1;
    check("mid_rst_rf_we", bus.rf_we_o, 0);
    check("mid_rst_alu_ready", bus.alu_ready_o, 0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    bus.rs1_addr_i = 9; bus.issue_addr_i = 9;
    #1;
    check("rel_alu_ready", bus.alu_ready_o, 1);
    check("rel_rs1_busy_x9", bus.rs1_busy_o, 0);
    check("rel_issue_busy_x9", bus.issue_busy_o, 0);
    idle(3);

    // single ALU write, ready low for exactly one cycle
    alu_send(5, 32'hDEAD_BEEF, 1);
    check("single_ready_low", bus.alu_ready_o, 0);
    check("single_rf_we", bus.rf_we_o, 1);
    @(posedge clk); #1;
    check("single_ready_back", bus.alu_ready_o, 1);
    check("single_we_done", bus.rf_we_o, 0);
    idle(2);

    // conflict: first ALU wins, then priority flips to LSU
    both_send(3, 32'h11, 4, 32'h22, 1);
    check("conflict1_we_c1", bus.rf_waddr_o, 3);
    @(posedge clk); #1;
    check("conflict1_we_c2", bus.rf_waddr_o, 4);
    check("conflict1_lsu_ready_wait", bus.lsu_ready_o, 0);
    idle(2);
    both_send(3, 32'h33, 4, 32'h44, 0);
    check("conflict2_lsu_first", bus.rf_waddr_o, 4);
    idle(3);

    // addr 0: handshake completes, nothing written or marked pending
    lsu_send(0, 32'h0000_FFFF, 0);
    check("x0_lsu_ready", bus.lsu_ready_o, 1);
    check("x0_rf_we", bus.rf_we_o, 0);
    bus.issue_valid_i = 1; bus.issue_addr_i = 0; bus.rs1_addr_i = 0;
    @(posedge clk); #1;
    bus.issue_valid_i = 0;
    check("x0_rs1_busy", bus.rs1_busy_o, 0);
    idle(2);

    // scoreboard: set, clear on commit, set wins over same-cycle commit
    bus.rs1_addr_i = 7; bus.rs2_addr_i = 7;
    bus.issue_valid_i = 1; bus.issue_addr_i = 7;
    #1;
    check("sb_no_bypass", bus.rs1_busy_o, 0);
    @(posedge clk); #1;
    bus.issue_valid_i = 0;
    check("sb_rs1_busy_set", bus.rs1_busy_o, 1);
    check("sb_rs2_busy_set", bus.rs2_busy_o, 1);
    check("sb_issue_busy_set", bus.issue_busy_o, 1);
    alu_send(7, 32'h0000_0077, 1);
    check("sb_busy_before_commit", bus.rs1_busy_o, 1);
    @(posedge clk); #1;
    check("sb_busy_cleared", bus.rs1_busy_o, 0);
    bus.issue_valid_i = 1; bus.issue_addr_i = 7;
    @(posedge clk); #1;
    bus.issue_valid_i = 0;
    alu_send(7, 32'h0000_0777, 1);
    bus.issue_valid_i = 1; bus.issue_addr_i = 7;
    @(posedge clk); #1;
    bus.issue_valid_i = 0;
    check("sb_set_wins", bus.rs1_busy_o, 1);
    alu_send(7, 32'h0000_7777, 1);
    @(posedge clk); #1;
    check("sb_final_clear", bus.rs2_busy_o, 0);
    idle(2);

    // back-to-back: both sources always valid; prio is back at ALU here, so ties go ALU first
    na = 0; nl = 0;
    bus.alu_valid_i = 1; bus.alu_addr_i = 1;  bus.alu_data_i = 32'hA000_0000;
    bus.lsu_valid_i = 1; bus.lsu_addr_i = 16; bus.lsu_data_i = 32'hB000_0000;
    for (int c = 0; c < 100 && (na < 10 || nl < 10); c++) begin
      @(negedge clk);
      a_acc = bus.alu_valid_i & bus.alu_ready_o;
      l_acc = bus.lsu_valid_i & bus.lsu_ready_o;
      if (a_acc) exp_q.push_back({bus.alu_addr_i, bus.alu_data_i});
      if (l_acc) exp_q.push_back({bus.lsu_addr_i, bus.lsu_data_i});
      @(posedge clk); #1;
      if (a_acc) begin
        na++;
        if (na < 10) begin
          bus.alu_addr_i = 5'(1 + na); bus.alu_data_i = 32'hA000_0000 + 32'(na);
        end else bus.alu_valid_i = 0;
      end
      if (l_acc) begin
        nl++;
        if (nl < 10) begin
          bus.lsu_addr_i = 5'(16 + nl); bus.lsu_data_i = 32'hB000_0000 + 32'(nl);
        end else bus.lsu_valid_i = 0;
      end
    end
    bus.alu_valid_i = 0; bus.lsu_valid_i = 0;
    check("b2b_accepts", 64'(na + nl), 20);
    idle(5);
    check("exp_q_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
